// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_ram
// Description : Simple dual-port frame buffer memory. One synchronous write
//               port and one registered read port whose output register
//               doubles as the stream output register of the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [c_DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage array: written on demand, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read register: loads only when the consumer side pulls a new beat, so it
  // holds its value while the downstream stalls.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_fifo
// Description : Single-clock AXI4-Stream frame FIFO. Frames are released to
//               the output only once their last beat is accepted good; bad
//               and overflowing frames are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_fifo #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter bit DROP_WHEN_FULL = 1'b0
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame
);

  localparam logic [ADDR_WIDTH:0] c_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] r_wr_ptr_commit;
  logic [ADDR_WIDTH:0] r_wr_ptr_cur;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] w_wr_ptr_commit_nxt;
  logic [ADDR_WIDTH:0] w_wr_ptr_cur_nxt;
  logic                r_drop_frame;
  logic                w_drop_frame_nxt;
  logic                r_overflow;
  logic                r_bad_frame;
  logic                r_good_frame;
  logic                w_overflow_nxt;
  logic                w_bad_frame_nxt;
  logic                w_good_frame_nxt;
  logic                r_out_tvalid;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_out_advance;
  logic                w_read;
  logic [DATA_WIDTH:0] w_rd_word;

  assign w_full  = (r_wr_ptr_cur[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr_cur[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_empty = (r_wr_ptr_commit == r_rd_ptr);

  // When nothing committed is waiting, a full memory means the current frame
  // alone is bigger than the buffer and can never be released: keep accepting
  // so it can be discarded instead of deadlocking the source.
  assign input_axis_tready = ~w_full | r_drop_frame | DROP_WHEN_FULL | w_empty;
  assign w_accept          = input_axis_tvalid & input_axis_tready;

  // Write side: store, commit, discard bad frames, or start dropping on overflow.
  always_comb begin
    w_wr_en             = 1'b0;
    w_wr_ptr_cur_nxt    = r_wr_ptr_cur;
    w_wr_ptr_commit_nxt = r_wr_ptr_commit;
    w_drop_frame_nxt    = r_drop_frame;
    w_overflow_nxt      = 1'b0;
    w_bad_frame_nxt     = 1'b0;
    w_good_frame_nxt    = 1'b0;
    if (w_accept) begin
      if (r_drop_frame) begin
        if (input_axis_tlast) begin
          w_drop_frame_nxt = 1'b0;
        end
      end else if (w_full && (DROP_WHEN_FULL || (r_wr_ptr_commit == r_rd_ptr))) begin
        w_wr_ptr_cur_nxt = r_wr_ptr_commit;
        w_overflow_nxt   = 1'b1;
        w_drop_frame_nxt = ~input_axis_tlast;
      end else begin
        w_wr_en          = 1'b1;
        w_wr_ptr_cur_nxt = r_wr_ptr_cur + c_PTR_ONE;
        if (input_axis_tlast) begin
          if (input_axis_tuser) begin
            w_wr_ptr_cur_nxt = r_wr_ptr_commit;
            w_bad_frame_nxt  = 1'b1;
          end else begin
            w_wr_ptr_commit_nxt = r_wr_ptr_cur + c_PTR_ONE;
            w_good_frame_nxt    = 1'b1;
          end
        end
      end
    end
  end

  // Write-side state and the one-cycle status pulses.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_wr_ptr_cur    <= '0;
      r_wr_ptr_commit <= '0;
      r_drop_frame    <= 1'b0;
      r_overflow      <= 1'b0;
      r_bad_frame     <= 1'b0;
      r_good_frame    <= 1'b0;
    end else begin
      r_wr_ptr_cur    <= w_wr_ptr_cur_nxt;
      r_wr_ptr_commit <= w_wr_ptr_commit_nxt;
      r_drop_frame    <= w_drop_frame_nxt;
      r_overflow      <= w_overflow_nxt;
      r_bad_frame     <= w_bad_frame_nxt;
      r_good_frame    <= w_good_frame_nxt;
    end
  end

  // The output register may be refilled when it is empty or being consumed.
  assign w_out_advance = output_axis_tready | ~r_out_tvalid;
  assign w_read        = w_out_advance & ~w_empty;

  // Read side: advance the read pointer and track output validity.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_rd_ptr     <= '0;
      r_out_tvalid <= 1'b0;
    end else begin
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_out_advance) begin
        r_out_tvalid <= ~w_empty;
      end
    end
  end

  axis_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (DATA_WIDTH + 1)
  ) u_ram (
    .clk       (clk),
    .async_rst (async_rst),
    .wr_en     (w_wr_en),
    .wr_addr   (r_wr_ptr_cur[ADDR_WIDTH-1:0]),
    .wr_data   ({input_axis_tlast, input_axis_tdata}),
    .rd_en     (w_read),
    .rd_addr   (r_rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data   (w_rd_word)
  );

  assign output_axis_tdata  = w_rd_word[DATA_WIDTH-1:0];
  assign output_axis_tlast  = w_rd_word[DATA_WIDTH];
  assign output_axis_tvalid = r_out_tvalid;
  assign overflow           = r_overflow;
  assign bad_frame          = r_bad_frame;
  assign good_frame         = r_good_frame;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_fifo
// Description : Self-checking bench for axis_frame_fifo (8-beat depth). dut0
//               backpressures when full, dut1 drops frames that hit full.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_fifo;

  logic clk = 1'b0;
  logic async_rst = 1'b1;

  logic       in_tvalid  [2];
  logic [7:0] in_tdata   [2];
  logic       in_tlast   [2];
  logic       in_tuser   [2];
  logic       in_tready  [2];
  logic [7:0] out_tdata  [2];
  logic       out_tvalid [2];
  logic       out_tready [2];
  logic       out_tlast  [2];
  logic       ovf        [2];
  logic       bad        [2];
  logic       good       [2];

  int tests = 0;
  int fails = 0;

  logic [8:0] oq0 [$];
  logic [8:0] oq1 [$];
  logic [8:0] expq [$];
  int gcnt [2] = '{0, 0};
  int ocnt [2] = '{0, 0};

  always #5 clk = ~clk;

  axis_frame_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DROP_WHEN_FULL(1'b0)) dut0 (
    .clk(clk), .async_rst(async_rst),
    .input_axis_tdata(in_tdata[0]), .input_axis_tvalid(in_tvalid[0]),
    .input_axis_tready(in_tready[0]), .input_axis_tlast(in_tlast[0]),
    .input_axis_tuser(in_tuser[0]),
    .output_axis_tdata(out_tdata[0]), .output_axis_tvalid(out_tvalid[0]),
    .output_axis_tready(out_tready[0]), .output_axis_tlast(out_tlast[0]),
    .overflow(ovf[0]), .bad_frame(bad[0]), .good_frame(good[0])
  );

  axis_frame_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DROP_WHEN_FULL(1'b1)) dut1 (
    .clk(clk), .async_rst(async_rst),
    .input_axis_tdata(in_tdata[1]), .input_axis_tvalid(in_tvalid[1]),
    .input_axis_tready(in_tready[1]), .input_axis_tlast(in_tlast[1]),
    .input_axis_tuser(in_tuser[1]),
    .output_axis_tdata(out_tdata[1]), .output_axis_tvalid(out_tvalid[1]),
    .output_axis_tready(out_tready[1]), .output_axis_tlast(out_tlast[1]),
    .overflow(ovf[1]), .bad_frame(bad[1]), .good_frame(good[1])
  );

  // Record every completed output handshake and status pulse, mid-cycle.
  always @(negedge clk) begin
    if (out_tvalid[0] && out_tready[0]) oq0.push_back({out_tlast[0], out_tdata[0]});
    if (out_tvalid[1] && out_tready[1]) oq1.push_back({out_tlast[1], out_tdata[1]});
    for (int k = 0; k < 2; k++) begin
      if (good[k]) gcnt[k]++;
      if (ovf[k])  ocnt[k]++;
    end
  end

  typedef struct packed {
    logic       tvalid;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;
    logic       ordy;
    logic       e_rdy;
    logic       e_val;
    logic [7:0] e_dat;
    logic       e_last;
    logic       e_good;
    logic       e_bad;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic tv, input logic [7:0] td, input logic tl,
                              input logic tu, input logic ordy, input logic erdy,
                              input logic evl, input logic [7:0] edat, input logic elast,
                              input logic eg, input logic eb, input logic eo);
    vec_t v;
    v = '{tv, td, tl, tu, ordy, erdy, evl, edat, elast, eg, eb, eo};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns cycles spent waiting.
  task automatic send_beat(input int d, input logic [7:0] data, input logic last,
                           input logic user, output int waited);
    logic rdy;
    waited = 0;
    in_tvalid[d] = 1'b1; in_tdata[d] = data; in_tlast[d] = last; in_tuser[d] = user;
    forever begin
      @(negedge clk);
      rdy = in_tready[d];
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 100) begin
        tests++; fails++;
        $display("FAIL send_beat timeout: dut%0d beat %0h never accepted", d, data);
        break;
      end
    end
    in_tvalid[d] = 1'b0; in_tlast[d] = 1'b0; in_tuser[d] = 1'b0;
  endtask

  task automatic send_seq(input int d, input logic [7:0] base, input int n);
    int w;
    for (int i = 0; i < n; i++) send_beat(d, base + 8'(i), (i == n - 1), 1'b0, w);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? oq0.size() : oq1.size();
  endfunction

  // Wait until n new output beats arrived (bounded), then settle a few cycles.
  task automatic wait_out(input int d, input int base, input int n);
    int c = 0;
    while ((qsize(d) - base) < n && c < 200) begin
      @(posedge clk); c++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic cmp_out(input string name, input int d, input int base);
    logic [8:0] a;
    check({name, " beat count"}, 32'(qsize(d) - base), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      a = 9'h1ff;
      if (base + i < qsize(d)) a = (d == 0) ? oq0[base + i] : oq1[base + i];
      check($sformatf("%s beat %0d", name, i), 32'(a), 32'(expq[i]));
    end
  endtask

  initial begin
    int w, base;
    logic [8:0] stall_exp [4];
    logic       stall_rdy [4];

    for (int k = 0; k < 2; k++) begin
      in_tvalid[k] = 1'b0; in_tdata[k] = 8'h00; in_tlast[k] = 1'b0;
      in_tuser[k] = 1'b0; out_tready[k] = 1'b0;
    end

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs dut0",
          {in_tready[0], out_tvalid[0], out_tdata[0], out_tlast[0], good[0], bad[0], ovf[0]},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset pointers dut0",
          {dut0.r_wr_ptr_cur, dut0.r_wr_ptr_commit, dut0.r_rd_ptr}, 0);
    @(negedge clk);
    async_rst = 1'b0;

    // ---------------- vector table: good frame, bad frame, oversize frame ----------------
    // Frame 11,22,33 (tuser on a non-last beat is ignored); commit then stream out.
    vecs.push_back(mk(1, 8'h11, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h22, 0, 1, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h33, 1, 0, 1,  1, 0, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 1, 8'h11, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 1, 8'h22, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 1, 8'h33, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    // Bad frame A0,A1 then single-beat frame 05.
    vecs.push_back(mk(1, 8'hA0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA1, 1, 1, 1,  1, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h05, 1, 0, 1,  1, 0, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 1, 8'h05, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    // 10-beat frame into an empty 8-beat buffer: ninth beat overflows.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 8'h80 + 8'(i), 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h88, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h89, 1, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 1, 0, 1,  1, 0, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 1, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 1, 8'h02, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      logic rdy_pre;
      in_tvalid[0] = vecs[i].tvalid; in_tdata[0] = vecs[i].tdata;
      in_tlast[0] = vecs[i].tlast; in_tuser[0] = vecs[i].tuser;
      out_tready[0] = vecs[i].ordy;
      #1;
      rdy_pre = in_tready[0];
      @(posedge clk);
      #1;
      check($sformatf("vector %0d", i),
            {rdy_pre, out_tvalid[0],
             out_tvalid[0] ? out_tdata[0] : 8'h00, out_tvalid[0] ? out_tlast[0] : 1'b0,
             good[0], bad[0], ovf[0]},
            {vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_dat, vecs[i].e_last,
             vecs[i].e_good, vecs[i].e_bad, vecs[i].e_ovf});
    end
    in_tvalid[0] = 1'b0; in_tlast[0] = 1'b0; in_tuser[0] = 1'b0;

    // ---------------- backpressure when full (dut0) ----------------
    // The output register prefetches 0x10, freeing one slot, so 0x20..0x22
    // fit and 0x23 is the beat that stalls.
    out_tready[0] = 1'b0;
    base = oq0.size();
    send_seq(0, 8'h10, 6);
    send_beat(0, 8'h20, 0, 0, w); check("bp 0x20 wait", 32'(w), 0);
    send_beat(0, 8'h21, 0, 0, w); check("bp 0x21 wait", 32'(w), 0);
    send_beat(0, 8'h22, 0, 0, w); check("bp 0x22 wait", 32'(w), 0);
    check("bp tready low when full", 32'(in_tready[0]), 0);
    in_tvalid[0] = 1'b1; in_tdata[0] = 8'h23; in_tlast[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp stall holds tready/output",
            {in_tready[0], out_tvalid[0], out_tlast[0], out_tdata[0]},
            {1'b0, 1'b1, 1'b0, 8'h10});
    end
    @(posedge clk); #1;
    out_tready[0] = 1'b1;
    send_beat(0, 8'h23, 1, 0, w);
    wait_out(0, base, 10);
    expq.delete();
    for (int i = 0; i < 6; i++) expq.push_back({(i == 5), 8'h10 + 8'(i)});
    for (int i = 0; i < 4; i++) expq.push_back({(i == 3), 8'h20 + 8'(i)});
    cmp_out("bp output", 0, base);
    check("bp no overflow", 32'(ocnt[0]), 1);

    // ---------------- drop when full (dut1) ----------------
    out_tready[1] = 1'b0;
    send_seq(1, 8'h10, 6);
    send_beat(1, 8'h20, 0, 0, w); check("drop 0x20 wait", 32'(w), 0);
    send_beat(1, 8'h21, 0, 0, w); check("drop 0x21 wait", 32'(w), 0);
    send_beat(1, 8'h22, 0, 0, w);
    check("drop 0x22 accepted/no ovf", {32'(w), 31'd0, ovf[1]}, 0);
    send_beat(1, 8'h23, 1, 0, w);
    check("drop 0x23 accepted/ovf", {32'(w), 31'd0, ovf[1]}, 1);
    check("drop tready high", 32'(in_tready[1]), 1);
    out_tready[1] = 1'b1;
    wait_out(1, 0, 6);
    expq.delete();
    for (int i = 0; i < 6; i++) expq.push_back({(i == 5), 8'h10 + 8'(i)});
    cmp_out("drop output", 1, 0);
    check("drop good/ovf counts", {gcnt[1], ocnt[1]}, {32'd1, 32'd1});

    // ---------------- output stall stability (dut0) ----------------
    out_tready[0] = 1'b0;
    base = oq0.size();
    send_seq(0, 8'h30, 4);
    @(posedge clk); #1;
    check("stall first beat", {out_tvalid[0], out_tlast[0], out_tdata[0]}, {1'b1, 1'b0, 8'h30});
    stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
    stall_exp = '{9'h031, 9'h031, 9'h031, 9'h032};
    for (int i = 0; i < 4; i++) begin
      out_tready[0] = stall_rdy[i];
      @(posedge clk); #1;
      check($sformatf("stall step %0d", i),
            {out_tvalid[0], out_tlast[0], out_tdata[0]}, {1'b1, stall_exp[i]});
    end
    @(posedge clk); #1;
    check("stall last beat", {out_tvalid[0], out_tlast[0], out_tdata[0]}, {1'b1, 1'b1, 8'h33});
    @(posedge clk); #1;
    check("stall drained", 32'(out_tvalid[0]), 0);
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back({(i == 3), 8'h30 + 8'(i)});
    cmp_out("stall output", 0, base);

    // ---------------- asynchronous reset mid-frame (dut0) ----------------
    out_tready[0] = 1'b0;
    send_beat(0, 8'h50, 1, 0, w);
    @(posedge clk); #1;
    check("pre-reset valid", {out_tvalid[0], out_tdata[0]}, {1'b1, 8'h50});
    send_beat(0, 8'h40, 0, 0, w);
    send_beat(0, 8'h41, 0, 0, w);
    #3;
    async_rst = 1'b1;
    #1;
    check("async reset outputs",
          {in_tready[0], out_tvalid[0], out_tdata[0], good[0], bad[0], ovf[0]},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("async reset pointers",
          {dut0.r_wr_ptr_cur, dut0.r_wr_ptr_commit, dut0.r_rd_ptr}, 0);
    @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    out_tready[0] = 1'b1;
    base = oq0.size();
    repeat (10) @(posedge clk);
    #1;
    check("post-reset no residue", {32'(oq0.size() - base), 31'd0, out_tvalid[0]}, 0);
    send_beat(0, 8'h60, 1, 0, w);
    wait_out(0, base, 1);
    expq.delete();
    expq.push_back(9'h160);
    cmp_out("post-reset frame", 0, base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
